// File: rtl/vga_pkg.sv
// Shared VGA raster constants (640x480 @ 60 Hz) and the coordinate type used
// by the timing generator and color_mapper.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: START inclusive, END exclusive.
    localparam int HS_START  = H_VISIBLE + H_FRONT;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_VISIBLE + V_FRONT;
    localparam int VS_END    = VS_START + V_SYNC;

    localparam int COORD_W   = 10;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_span(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its consumers (color_mapper and
// the VGA sync pins).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       pixel_clk;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       blank;
    coord_t     DrawX;
    coord_t     DrawY;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        output pixel_clk, pix_en, hs, vs, blank, DrawX, DrawY,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        input  pixel_clk, pix_en, hs, vs, blank, DrawX, DrawY,
               line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active-low sync
// and a look-ahead active flag. Axes chain through wrap (H wrap advances V).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE,
    parameter int FRONT   = H_FRONT,
    parameter int SYNC    = H_SYNC,
    parameter int BACK    = H_BACK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   adv,
    output coord_t count,
    output logic   sync_n,
    output logic   active,
    output logic   wrap
);

    localparam int     TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t VIS_END    = coord_t'(VISIBLE);
    localparam coord_t SYNC_START = coord_t'(VISIBLE + FRONT);
    localparam coord_t SYNC_END   = coord_t'(VISIBLE + FRONT + SYNC);

    coord_t count_nxt;

    always_comb begin
        count_nxt = count;
        if (adv) begin
            count_nxt = (count == LAST) ? '0 : count + coord_t'(1);
        end
    end

    assign wrap   = adv && (count == LAST);
    // Reflects the next position so the parent can register a combined
    // display-enable on the same edge the counters move.
    assign active = (count_nxt < VIS_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            sync_n <= 1'b1;
        end else begin
            count  <= count_nxt;
            sync_n <= !in_span(count_nxt, SYNC_START, SYNC_END);
        end
    end

    a_count_in_range: assert property (@(posedge clk) disable iff (rst) count <= LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider feeding chained horizontal and
// vertical counters; all qualifiers are registered alongside DrawX/DrawY.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int CLK_DIV   = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    vga_timing_gen_if.master bus
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             pix_en;
    logic             pixel_clk;

    coord_t     h_count;
    coord_t     v_count;
    logic       h_sync_n;
    logic       v_sync_n;
    logic       h_active;
    logic       v_active;
    logic       h_wrap;
    logic       v_wrap;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;

    always_comb begin
        div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end

    // pix_en and pixel_clk are decoded from the next divider value so they
    // line up with div itself rather than trailing it by a cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div       <= '0;
            pix_en    <= 1'b0;
            pixel_clk <= 1'b0;
        end else begin
            div       <= div_nxt;
            pix_en    <= (div_nxt == DIV_LAST);
            pixel_clk <= (div_nxt >= DIV_HALF);
        end
    end

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk    (Clk),
        .rst    (Reset),
        .adv    (pix_en),
        .count  (h_count),
        .sync_n (h_sync_n),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk    (Clk),
        .rst    (Reset),
        .adv    (h_wrap),
        .count  (v_count),
        .sync_n (v_sync_n),
        .active (v_active),
        .wrap   (v_wrap)
    );

    // Markers only update on pixel advances, so each spans a full pixel
    // period; the period right after reset never raises them.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            blank <= h_active && v_active;
            if (pix_en) begin
                line_start  <= h_wrap;
                frame_start <= v_wrap;
                if (v_wrap) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.pixel_clk   = pixel_clk;
    assign bus.pix_en      = pix_en;
    assign bus.hs          = h_sync_n;
    assign bus.vs          = v_sync_n;
    assign bus.blank       = blank;
    assign bus.DrawX       = h_count;
    assign bus.DrawY       = v_count;
    assign bus.line_start  = line_start;
    assign bus.frame_start = frame_start;
    assign bus.frame_cnt   = frame_cnt;

    a_pix_strobe: assert property (@(posedge Clk) disable iff (Reset) pix_en |=> !pix_en);
    a_frame_line: assert property (@(posedge Clk) disable iff (Reset) frame_start |-> line_start);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster (CLK_DIV 2 and 4) plus a
// miniature raster used for frame wrap, frame counter rollover and mid-sync reset.
module tb_vga_timing_gen;

    localparam int S_HV = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VV = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct packed {
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic blank;
        logic ls;
        logic fs;
        int   fc;
    } obs_t;

    typedef struct packed {
        int   p;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic blank;
        logic ls;
    } vec_t;

    logic Clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_s = 1'b0;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    obs_t sb_a[$];
    obs_t sb_s[$];

    always #5 Clk = ~Clk;

    vga_timing_gen_if bus_a ();
    vga_timing_gen_if bus_b ();
    vga_timing_gen_if bus_s ();

    vga_timing_gen u_a (.Clk(Clk), .Reset(rst_a), .bus(bus_a));

    vga_timing_gen #(.CLK_DIV(4)) u_b (.Clk(Clk), .Reset(rst_b), .bus(bus_b));

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .CLK_DIV(2)
    ) u_s (.Clk(Clk), .Reset(rst_s), .bus(bus_s));

    function automatic obs_t mk(input int x, input int y, input logic hs, input logic vs,
                                input logic blank, input logic ls, input logic fs, input int fc);
        obs_t o;
        o.x = x; o.y = y; o.hs = hs; o.vs = vs;
        o.blank = blank; o.ls = ls; o.fs = fs; o.fc = fc;
        return o;
    endfunction

    function automatic obs_t sample(input int which);
        obs_t o;
        o = '0;
        if (which == 0)
            o = mk(int'(bus_a.DrawX), int'(bus_a.DrawY), bus_a.hs, bus_a.vs, bus_a.blank,
                   bus_a.line_start, bus_a.frame_start, int'(bus_a.frame_cnt));
        else if (which == 1)
            o = mk(int'(bus_b.DrawX), int'(bus_b.DrawY), bus_b.hs, bus_b.vs, bus_b.blank,
                   bus_b.line_start, bus_b.frame_start, int'(bus_b.frame_cnt));
        else
            o = mk(int'(bus_s.DrawX), int'(bus_s.DrawY), bus_s.hs, bus_s.vs, bus_s.blank,
                   bus_s.line_start, bus_s.frame_start, int'(bus_s.frame_cnt));
        return o;
    endfunction

    function automatic logic pe(input int which);
        return (which == 0) ? bus_a.pix_en : (which == 1) ? bus_b.pix_en : bus_s.pix_en;
    endfunction

    function automatic logic pclk(input int which);
        return (which == 0) ? bus_a.pixel_clk : (which == 1) ? bus_b.pixel_clk : bus_s.pixel_clk;
    endfunction

    // Reference for the miniature raster after p pixel advances since reset.
    function automatic obs_t model_s(input int p);
        int x;
        int y;
        x = p % S_HT;
        y = (p / S_HT) % S_VT;
        return mk(x, y,
                  !((x >= S_HV + S_HF) && (x < S_HV + S_HF + S_HS)),
                  !((y >= S_VV + S_VF) && (y < S_VV + S_VF + S_VS)),
                  (x < S_HV) && (y < S_VV),
                  (p > 0) && (x == 0),
                  (p > 0) && (x == 0) && (y == 0),
                  (p / S_FRAME) % 256);
    endfunction

    task automatic add(input int p, input int x, input int y, input logic hs, input logic vs,
                       input logic blank, input logic ls);
        vec_t v;
        v.p = p; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.blank = blank; v.ls = ls;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".DrawX"}, act.x, exp.x);
        chk({tag, ".DrawY"}, act.y, exp.y);
        chk({tag, ".hs"}, int'(act.hs), int'(exp.hs));
        chk({tag, ".vs"}, int'(act.vs), int'(exp.vs));
        chk({tag, ".blank"}, int'(act.blank), int'(exp.blank));
        chk({tag, ".line_start"}, int'(act.ls), int'(exp.ls));
        chk({tag, ".frame_start"}, int'(act.fs), int'(exp.fs));
        chk({tag, ".frame_cnt"}, act.fc, exp.fc);
    endtask

    task automatic chk_reset(input string tag, input int which);
        cmp(tag, sample(which), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        chk({tag, ".pix_en"}, int'(pe(which)), 0);
        chk({tag, ".pixel_clk"}, int'(pclk(which)), 0);
    endtask

    // Consume n pixel advances; returns 1 time unit after the advancing edge.
    task automatic step(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            bit got;
            got = 1'b0;
            for (int t = 0; t < 16 && !got; t++) begin
                @(negedge Clk);
                if (pe(which)) begin
                    @(posedge Clk);
                    #1;
                    got = 1'b1;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL step_timeout inst=%0d: got no pix_en, expected one within 16 Clk", which);
                return;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected one before 600000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add(639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1);
        add(801,  1,   1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1456, 656, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1599, 799, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1600, 0,   2, 1'b1, 1'b1, 1'b1, 1'b1);

        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_s = 1'b1;
        #1;
        chk_reset("A.reset_async", 0);
        chk_reset("B.reset_async", 1);
        chk_reset("S.reset_async", 2);
        repeat (3) @(posedge Clk);
        #1;
        chk_reset("A.reset_held", 0);
        @(negedge Clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_s = 1'b0;

        fork
            begin : proc_a
                int cur;
                int blank_low;
                int hs_low;
                for (int k = 1; k <= 6; k++) begin
                    @(posedge Clk);
                    #1;
                    chk($sformatf("A.pix_en edge%0d", k), int'(bus_a.pix_en), k % 2);
                    chk($sformatf("A.DrawX edge%0d", k), int'(bus_a.DrawX), k / 2);
                    chk($sformatf("A.line_start edge%0d", k), int'(bus_a.line_start), 0);
                end
                cur = 3;
                foreach (vecs[i]) begin
                    step(0, vecs[i].p - cur);
                    cur = vecs[i].p;
                    sb_a.push_back(mk(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs,
                                      vecs[i].blank, vecs[i].ls, 1'b0, 0));
                    cmp($sformatf("A p=%0d", cur), sample(0), sb_a.pop_front());
                end
                blank_low = 0;
                hs_low = 0;
                for (int i = 0; i < 800; i++) begin
                    if (!bus_a.blank) blank_low++;
                    if (!bus_a.hs) hs_low++;
                    step(0, 1);
                end
                chk("A.line2_blank_low_pixels", blank_low, 160);
                chk("A.line2_hs_low_pixels", hs_low, 96);
            end

            begin : proc_b
                int pulses;
                int low;
                int x_fall;
                int x_rise;
                for (int k = 1; k <= 8; k++) begin
                    @(posedge Clk);
                    #1;
                    chk($sformatf("B.pix_en edge%0d", k), int'(bus_b.pix_en), int'(k % 4 == 3));
                    chk($sformatf("B.pixel_clk edge%0d", k), int'(bus_b.pixel_clk), int'(k % 4 >= 2));
                    chk($sformatf("B.DrawX edge%0d", k), int'(bus_b.DrawX), k / 4);
                end
                pulses = 0;
                for (int c = 0; c < 40; c++) begin
                    @(posedge Clk);
                    #1;
                    if (bus_b.pix_en) pulses++;
                end
                chk("B.pix_en_per_40clk", pulses, 10);
                low = 0;
                x_fall = -1;
                x_rise = -1;
                for (int c = 0; c < 4000 && x_rise < 0; c++) begin
                    @(posedge Clk);
                    #1;
                    if (!bus_b.hs) begin
                        if (low == 0) x_fall = int'(bus_b.DrawX);
                        low++;
                    end else if (low > 0) begin
                        x_rise = int'(bus_b.DrawX);
                    end
                end
                chk("B.hs_low_clk", low, 384);
                chk("B.DrawX_at_hs_fall", x_fall, 656);
                chk("B.DrawX_at_hs_rise", x_rise, 752);
            end

            begin : proc_s
                int vs_low;
                int p;
                @(posedge Clk);
                #1;
                cmp("S p=0", sample(2), model_s(0));
                vs_low = bus_s.vs ? 0 : 1;
                for (p = 1; p <= 2 * S_FRAME; p++) begin
                    step(2, 1);
                    sb_s.push_back(model_s(p));
                    cmp($sformatf("S p=%0d", p), sample(2), sb_s.pop_front());
                    if (p < S_FRAME && !bus_s.vs) vs_low++;
                end
                chk("S.vs_low_pixels", vs_low, S_VS * S_HT);

                step(2, 255 * S_FRAME - 2 * S_FRAME);
                cmp("S frame255", sample(2), model_s(255 * S_FRAME));
                step(2, S_FRAME);
                cmp("S frame256", sample(2), model_s(256 * S_FRAME));
                chk("S.frame_cnt_rollover", int'(bus_s.frame_cnt), 0);
                step(2, 1);
                cmp("S frame256+1", sample(2), model_s(256 * S_FRAME + 1));

                // Park inside both syncs (x=5, y=4), mid pixel period.
                step(2, 4 * S_HT + 5 - 1);
                cmp("S mid_sync", sample(2), model_s(257 * S_FRAME + 4 * S_HT + 5 - S_FRAME));
                @(posedge Clk);
                #2;
                rst_s = 1'b1;
                #1;
                chk_reset("S.reset_mid_sync", 2);
                repeat (2) @(posedge Clk);
                @(negedge Clk);
                rst_s = 1'b0;
                @(posedge Clk);
                #1;
                cmp("S after_reset p=0", sample(2), model_s(0));
                for (p = 1; p <= 10; p++) begin
                    step(2, 1);
                    sb_s.push_back(model_s(p));
                    cmp($sformatf("S after_reset p=%0d", p), sample(2), sb_s.pop_front());
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
